mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 139 +++++++++++++
 tb/tb_mem_arbiter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : mem_arbiter                                          |
// | Description : Two-port round-robin arbiter in front of a single    |
// |               input-registered / output-unregistered RAM.          |
// |               One access at a time: IDLE -> ACCESS -> (RD_WAIT) -> |
// |               ACK -> IDLE.                                         |
// | Revision    : 1.0  initial release                                 |
// +--------------------------------------------------------------------+
module mem_arbiter #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic          req0,
  input  logic          req1,
  input  logic          wr0,
  input  logic          wr1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          ack0,
  output logic          ack1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic          busy,
  output logic [AW-1:0] ram_address,
  output logic [DW-1:0] ram_data,
  output logic          ram_wren,
  input  logic [DW-1:0] ram_q
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RD_WAIT = 2'd2,
    ACK     = 2'd3
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic          w_grant;
  logic          w_winner;
  logic          w_ack0;
  logic          w_ack1;
  logic          w_busy;
  logic          r_gnt;
  logic          r_last;
  logic          r_wren;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_data;
  logic [DW-1:0] r_rdata0;
  logic [DW-1:0] r_rdata1;

  // Next-state, arbitration decision and state-decoded outputs.
  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_winner    = r_gnt;
    w_ack0      = 1'b0;
    w_ack1      = 1'b0;
    w_busy      = 1'b1;
    case (r_state)
      IDLE: begin
        w_busy = 1'b0;
        if (req0 || req1) begin
          w_state_nxt = ACCESS;
          w_grant     = 1'b1;
          // On a tie the port that was not served last wins; otherwise
          // the single requester wins (req1 alone selects port 1).
          w_winner    = (req0 && req1) ? ~r_last : req1;
        end
      end
      ACCESS:  w_state_nxt = r_wren ? ACK : RD_WAIT;
      RD_WAIT: w_state_nxt = ACK;
      ACK: begin
        w_state_nxt = IDLE;
        w_ack0      = ~r_gnt;
        w_ack1      = r_gnt;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register; reset returns to IDLE immediately, aborting any access.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Grant capture and RAM-side request registers; wren lives only in ACCESS.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_gnt  <= 1'b0;
      r_last <= 1'b1;
      r_wren <= 1'b0;
      r_addr <= '0;
      r_data <= '0;
    end else if (w_grant) begin
      r_gnt  <= w_winner;
      r_last <= w_winner;
      r_wren <= w_winner ? wr1    : wr0;
      r_addr <= w_winner ? addr1  : addr0;
      r_data <= w_winner ? wdata1 : wdata0;
    end else if (r_state == ACCESS) begin
      r_wren <= 1'b0;
    end
  end

  // Read-data capture: RAM output is valid during RD_WAIT.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_rdata0 <= '0;
      r_rdata1 <= '0;
    end else if (r_state == RD_WAIT) begin
      if (r_gnt) begin
        r_rdata1 <= ram_q;
      end else begin
        r_rdata0 <= ram_q;
      end
    end
  end

  assign ack0        = w_ack0;
  assign ack1        = w_ack1;
  assign busy        = w_busy;
  assign rdata0      = r_rdata0;
  assign rdata1      = r_rdata1;
  assign ram_address = r_addr;
  assign ram_data    = r_data;
  assign ram_wren    = r_wren;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : tb_mem_arbiter                                       |
// | Description : Self-checking bench for mem_arbiter with a RAM model |
// |               and a transaction-level reference model.             |
// | Revision    : 1.0  initial release                                 |
// +--------------------------------------------------------------------+
module tb_mem_arbiter;

  logic       clk;
  logic       resetn;
  logic [1:0] tb_req;
  logic [1:0] tb_wr;
  logic [7:0] tb_addr [2];
  logic [7:0] tb_wd   [2];
  logic       ack0, ack1, busy, ram_wren;
  logic [7:0] rdata0, rdata1, ram_address, ram_data, ram_q;

  int n_pass  = 0;
  int n_total = 0;

  mem_arbiter #(.AW(8), .DW(8)) dut (
    .clock(clk), .resetn(resetn),
    .req0(tb_req[0]), .req1(tb_req[1]),
    .wr0(tb_wr[0]), .wr1(tb_wr[1]),
    .addr0(tb_addr[0]), .addr1(tb_addr[1]),
    .wdata0(tb_wd[0]), .wdata1(tb_wd[1]),
    .ack0(ack0), .ack1(ack1),
    .rdata0(rdata0), .rdata1(rdata1),
    .busy(busy),
    .ram_address(ram_address), .ram_data(ram_data), .ram_wren(ram_wren),
    .ram_q(ram_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM: address and write registered on the clock, output unregistered.
  logic [7:0] ram_mem [256];
  logic [7:0] ram_qaddr = 8'h00;
  initial for (int i = 0; i < 256; i++) ram_mem[i] = 8'h00;
  always @(posedge clk) begin
    if (ram_wren) ram_mem[ram_address] <= ram_data;
    ram_qaddr <= ram_address;
  end
  assign ram_q = ram_mem[ram_qaddr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Transaction-level reference: an access occupies a fixed number of
  // cycles after its grant (2 for write, 3 for read); ack is the last one.
  logic [7:0] m_mem [256];
  initial for (int i = 0; i < 256; i++) m_mem[i] = 8'h00;
  bit         m_busy = 0;
  int         m_age  = 0;
  int         m_gnt  = 0;
  int         m_last = 1;
  bit         m_wr   = 0;
  logic [7:0] m_addr = 0, m_dat = 0, m_ra = 0, m_rdat = 0;
  logic [7:0] m_rd [2] = '{8'h00, 8'h00};

  function automatic int op_len(input bit wr);
    return wr ? 2 : 3;
  endfunction

  // Advance the model over the edge just passed, then compare every output.
  always @(negedge clk) begin
    if (!resetn) begin
      m_busy = 0; m_age = 0; m_last = 1;
      m_rd[0] = 0; m_rd[1] = 0; m_ra = 0; m_rdat = 0;
    end else if (m_busy) begin
      m_age++;
      if (m_wr && m_age == 2) m_mem[m_addr] = m_dat;
      if (!m_wr && m_age == 3) m_rd[m_gnt] = m_mem[m_addr];
      if (m_age > op_len(m_wr)) m_busy = 0;
    end else if (tb_req != 2'b00) begin
      m_gnt  = (tb_req == 2'b11) ? (1 - m_last) : (tb_req[1] ? 1 : 0);
      m_last = m_gnt;
      m_wr   = tb_wr[m_gnt];
      m_addr = tb_addr[m_gnt];
      m_dat  = tb_wd[m_gnt];
      m_ra   = m_addr;
      m_rdat = m_dat;
      m_busy = 1;
      m_age  = 1;
    end
    chk("busy", busy, m_busy);
    chk("ack0", ack0, m_busy && m_age == op_len(m_wr) && m_gnt == 0);
    chk("ack1", ack1, m_busy && m_age == op_len(m_wr) && m_gnt == 1);
    chk("ram_wren", ram_wren, m_busy && m_wr && m_age == 1);
    chk("ram_address", ram_address, m_ra);
    chk("ram_data", ram_data, m_rdat);
    chk("rdata0", rdata0, m_rd[0]);
    chk("rdata1", rdata1, m_rd[1]);
  end

  function automatic logic ack_of(input int p);
    return (p == 0) ? ack0 : ack1;
  endfunction

  task automatic step();
    @(negedge clk); #1;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 10 && busy; i++) step();
    step();
  endtask

  // One transaction on one port from an idle arbiter; checks latency.
  task automatic do_txn(input int p, input logic w, input logic [7:0] a,
                        input logic [7:0] d, input int exp_lat);
    int lat;
    wait_idle();
    tb_wr[p] = w; tb_addr[p] = a; tb_wd[p] = d; tb_req[p] = 1'b1;
    lat = 0;
    for (int i = 1; i <= 10 && lat == 0; i++) begin
      step();
      if (i == 1) begin
        chk("access_wren", ram_wren, w);
        chk("access_addr", ram_address, a);
        if (w) chk("access_data", ram_data, d);
      end
      if (ack_of(p)) lat = i;
    end
    tb_req[p] = 1'b0;
    chk("latency", lat, exp_lat);
  endtask

  task automatic new_txn(input int p);
    tb_wr[p]   = 1'($urandom % 2);
    tb_addr[p] = 8'($urandom_range(0, 7));
    tb_wd[p]   = 8'($urandom);
    tb_req[p]  = 1'b1;
  endtask

  int order [8];
  int n_ack;

  initial begin
    resetn = 1'b0;
    tb_req = 2'b00; tb_wr = 2'b00;
    tb_addr[0] = 0; tb_addr[1] = 0; tb_wd[0] = 0; tb_wd[1] = 0;
    repeat (3) step();
    chk("reset_busy", busy, 0);
    chk("reset_rdata0", rdata0, 0);
    chk("reset_addr", ram_address, 0);
    resetn = 1'b1;

    // Port 0 write, then port 1 read of the same location.
    do_txn(0, 1'b1, 8'h0F, 8'h1E, 2);
    do_txn(1, 1'b0, 8'h0F, 8'h00, 3);
    chk("rd1_0F", rdata1, 8'h1E);
    chk("rd0_unchanged", rdata0, 8'h00);

    // Both ports requesting straight out of reset: port 0 first.
    resetn = 1'b0;
    tb_wr = 2'b11;
    tb_addr[0] = 8'h0F; tb_wd[0] = 8'h1E;
    tb_addr[1] = 8'hF0; tb_wd[1] = 8'h03;
    tb_req = 2'b11;
    step();
    resetn = 1'b1;
    n_ack = 0;
    for (int i = 0; i < 20 && n_ack < 2; i++) begin
      step();
      chk("no_overlap", ack0 & ack1, 0);
      for (int p = 0; p < 2; p++)
        if (ack_of(p) && n_ack < 8) begin order[n_ack] = p; n_ack++; tb_req[p] = 1'b0; end
    end
    chk("tie_count", n_ack, 2);
    chk("tie_first", order[0], 0);
    chk("tie_second", order[1], 1);
    do_txn(0, 1'b0, 8'h0F, 8'h00, 3);
    chk("rd0_0F", rdata0, 8'h1E);
    do_txn(1, 1'b0, 8'hF0, 8'h00, 3);
    chk("rd1_F0", rdata1, 8'h03);

    // Continuous requests from both ports: grants must alternate.
    wait_idle();
    tb_wr = 2'b11;
    tb_addr[0] = 8'h40; tb_addr[1] = 8'h41;
    tb_req = 2'b11;
    n_ack = 0;
    for (int i = 0; i < 60 && n_ack < 8; i++) begin
      step();
      chk("no_overlap", ack0 & ack1, 0);
      for (int p = 0; p < 2; p++)
        if (ack_of(p) && n_ack < 8) begin
          order[n_ack] = p; n_ack++;
          tb_wd[p] = 8'($urandom);
        end
    end
    tb_req = 2'b00;
    chk("rr_count", n_ack, 8);
    chk("rr_first", order[0], 0);
    for (int k = 1; k < 8; k++) chk("rr_alternate", order[k] != order[k-1], 1);

    // Reset in the middle of a write: aborted, no ack, old data kept.
    wait_idle();
    tb_wr[0] = 1'b1; tb_addr[0] = 8'hF0; tb_wd[0] = 8'h55; tb_req[0] = 1'b1;
    step();
    chk("abort_wren_before", ram_wren, 1);
    resetn = 1'b0;
    #1;
    chk("abort_wren", ram_wren, 0);
    chk("abort_busy", busy, 0);
    tb_req = 2'b00;
    step();
    resetn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("abort_no_ack", ack0 | ack1, 0);
    end
    do_txn(1, 1'b0, 8'hF0, 8'h00, 3);
    chk("abort_rd_F0", rdata1, 8'h03);

    // Randomized traffic with a reset pulse in the middle.
    for (int cyc = 0; cyc < 1500; cyc++) begin
      step();
      if (cyc == 700) begin resetn = 1'b0; tb_req = 2'b00; end
      else if (cyc == 702) resetn = 1'b1;
      else if (resetn) begin
        for (int p = 0; p < 2; p++) begin
          if (tb_req[p] && ack_of(p)) begin
            tb_req[p] = 1'b0;
            if ($urandom % 2 == 0) new_txn(p);
          end else if (!tb_req[p] && $urandom % 3 == 0) begin
            new_txn(p);
          end
        end
      end
    end
    tb_req = 2'b00;
    repeat (5) step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
